// File: rtl/pip_hazard_ctrl_if.sv
// Pipeline hazard control bus: the hazard-relevant fields of every pipeline
// register, plus the enables, flush/bubble controls, forwarding selects and
// status returned by the controller.
// slave modport = the controller, master modport = the pipeline datapath.
interface pip_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1_ad;
   logic [4:0]       id_rs2_ad;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [4:0]       ex_rs1_ad;
   logic [4:0]       ex_rs2_ad;
   logic [4:0]       ex_rd_ad;
   logic             ex_rdEn;
   logic             ex_DMread;
   logic [4:0]       mem_rd_ad;
   logic             mem_rdEn;
   logic             mem_DMread;
   logic             mem_DMwriteEn;
   logic [4:0]       wb_rd_ad;
   logic             wb_rdEn;
   logic             br_taken;
   logic             dm_ready;

   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic             dm_timeout;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_rs1_ad, id_rs2_ad, id_rs1_used, id_rs2_used,
             ex_rs1_ad, ex_rs2_ad, ex_rd_ad, ex_rdEn, ex_DMread,
             mem_rd_ad, mem_rdEn, mem_DMread, mem_DMwriteEn,
             wb_rd_ad, wb_rdEn, br_taken, dm_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_bubble, fwd_a_sel, fwd_b_sel,
             dm_timeout, stall_cycles
   );

   modport slave (
      input  id_rs1_ad, id_rs2_ad, id_rs1_used, id_rs2_used,
             ex_rs1_ad, ex_rs2_ad, ex_rd_ad, ex_rdEn, ex_DMread,
             mem_rd_ad, mem_rdEn, mem_DMread, mem_DMwriteEn,
             wb_rd_ad, wb_rdEn, br_taken, dm_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_bubble, fwd_a_sel, fwd_b_sel,
             dm_timeout, stall_cycles
   );
endinterface

// File: rtl/pip_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RISC-V core: pipeline
// enables, IF/ID flush, ID/EX bubble, EX operand forwarding, load-use and
// RAW stalls, data-memory wait with timeout trap, stall-cycle counter.
//
// Build option: FORWARDING_EN
//   defined   -> forwarding selects active, only load-use stalls
//   undefined -> selects tied to 00, any ID source matching EX or MEM rd stalls
//
// state    | meaning
// RUN      | normal sequencing, hazard rules evaluated every cycle
// MEM_WAIT | data memory busy, whole pipe frozen, wait counter running
// HALT     | memory wait timed out, pipe frozen until reset
module pip_hazard_ctrl #(
   parameter int DM_WAIT_MAX = 15,
   parameter int CNT_W       = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   pip_hazard_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_MAX = 8'(DM_WAIT_MAX);

   state_t           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
   logic flush_c, bubble_c;
   logic [1:0] fwd_a_c, fwd_b_c;

   logic rs1_ex_hit, rs2_ex_hit;
   logic load_use, raw_stall, mem_pending;

   // A source matches a stage only when used, nonzero, and the stage writes rd.
   function automatic logic src_match(input logic [4:0] src, input logic used,
                                      input logic [4:0] rd, input logic rd_en);
      return used && (src != 5'd0) && rd_en && (src == rd);
   endfunction

   // Hazard detection against the ID instruction's sources.
   always_comb begin
      rs1_ex_hit  = src_match(bus.id_rs1_ad, bus.id_rs1_used, bus.ex_rd_ad, bus.ex_rdEn);
      rs2_ex_hit  = src_match(bus.id_rs2_ad, bus.id_rs2_used, bus.ex_rd_ad, bus.ex_rdEn);
      load_use    = bus.ex_DMread && (rs1_ex_hit || rs2_ex_hit);
      mem_pending = (bus.mem_DMread || bus.mem_DMwriteEn) && !bus.dm_ready;
   end

`ifdef FORWARDING_EN
   // With forwarding only a load result is too late for the EX stage.
   always_comb begin
      raw_stall = load_use;
   end

   // EX operand sources; the younger EX/MEM result beats MEM/WB, and a load
   // in EX/MEM has no result yet so it falls through to MEM/WB.
   always_comb begin
      fwd_a_c = 2'b00;
      fwd_b_c = 2'b00;
      if (src_match(bus.ex_rs1_ad, 1'b1, bus.mem_rd_ad, bus.mem_rdEn) && !bus.mem_DMread)
         fwd_a_c = 2'b01;
      else if (src_match(bus.ex_rs1_ad, 1'b1, bus.wb_rd_ad, bus.wb_rdEn))
         fwd_a_c = 2'b10;
      if (src_match(bus.ex_rs2_ad, 1'b1, bus.mem_rd_ad, bus.mem_rdEn) && !bus.mem_DMread)
         fwd_b_c = 2'b01;
      else if (src_match(bus.ex_rs2_ad, 1'b1, bus.wb_rd_ad, bus.wb_rdEn))
         fwd_b_c = 2'b10;
   end
`else
   logic rs1_mem_hit, rs2_mem_hit;
   logic unused_fwd;

   // Without forwarding the ID instruction waits until producers reach WB;
   // WB itself is covered by register-file write-through.
   always_comb begin
      rs1_mem_hit = src_match(bus.id_rs1_ad, bus.id_rs1_used, bus.mem_rd_ad, bus.mem_rdEn);
      rs2_mem_hit = src_match(bus.id_rs2_ad, bus.id_rs2_used, bus.mem_rd_ad, bus.mem_rdEn);
      raw_stall   = rs1_ex_hit || rs2_ex_hit || rs1_mem_hit || rs2_mem_hit;
      fwd_a_c     = 2'b00;
      fwd_b_c     = 2'b00;
   end

   assign unused_fwd = ^{bus.ex_rs1_ad, bus.ex_rs2_ad, bus.wb_rd_ad, bus.wb_rdEn, load_use};
`endif

   // Next state and pipeline controls; MEM_WAIT exit re-runs the RUN rules
   // in the same cycle so the pipe restarts without a dead cycle.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      pc_en_c     = 1'b0;
      if_id_en_c  = 1'b0;
      id_ex_en_c  = 1'b0;
      ex_mem_en_c = 1'b0;
      mem_wb_en_c = 1'b0;
      flush_c     = 1'b0;
      bubble_c    = 1'b0;

      unique case (state_q)
         RUN, MEM_WAIT: begin
            if (state_q == MEM_WAIT && !bus.dm_ready) begin
               if (wait_cnt_q >= WAIT_MAX) begin
                  timeout_d = 1'b1;
                  state_d   = HALT;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end else begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
               if (mem_pending) begin
                  state_d    = MEM_WAIT;
                  wait_cnt_d = 8'd1;
               end else begin
                  pc_en_c     = 1'b1;
                  if_id_en_c  = 1'b1;
                  id_ex_en_c  = 1'b1;
                  ex_mem_en_c = 1'b1;
                  mem_wb_en_c = 1'b1;
                  if (bus.br_taken) begin
                     flush_c  = 1'b1;
                     bubble_c = 1'b1;
                  end else if (raw_stall) begin
                     pc_en_c    = 1'b0;
                     if_id_en_c = 1'b0;
                     bubble_c   = 1'b1;
                  end
               end
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = HALT;
         end
      endcase
   end

   // Outputs are forced inactive while reset is asserted.
   always_comb begin
      bus.pc_en        = rst_n & pc_en_c;
      bus.if_id_en     = rst_n & if_id_en_c;
      bus.id_ex_en     = rst_n & id_ex_en_c;
      bus.ex_mem_en    = rst_n & ex_mem_en_c;
      bus.mem_wb_en    = rst_n & mem_wb_en_c;
      bus.if_id_flush  = rst_n & flush_c;
      bus.id_ex_bubble = rst_n & bubble_c;
      bus.fwd_a_sel    = rst_n ? fwd_a_c : 2'b00;
      bus.fwd_b_sel    = rst_n ? fwd_b_c : 2'b00;
      bus.dm_timeout   = timeout_q;
      bus.stall_cycles = stall_q;
   end

   // Saturating count of cycles in which the PC is held.
   always_comb begin
      stall_d = stall_q;
      if (!pc_en_c && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // State, wait counter, sticky timeout and stall counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         wait_cnt_q <= 8'd0;
         timeout_q  <= 1'b0;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
         stall_q    <= stall_d;
      end
   end

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// Scoreboard bench for pip_hazard_ctrl: stimulus pushes the hand-derived
// expected controls for each cycle, a monitor pops and compares at negedge.
// Expectations adapt to whether FORWARDING_EN is defined.
module tb_pip_hazard_ctrl;
   localparam int CNT_W = 32;
`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int S = FWD ? 1 : 3;

   localparam logic [6:0] EN_OFF = 7'b0000000;
   localparam logic [6:0] EN_RUN = 7'b1111100;
   localparam logic [6:0] EN_LU  = 7'b0011101;
   localparam logic [6:0] EN_BR  = 7'b1111111;

   typedef struct packed {
      logic [6:0]  en;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        to;
      logic [31:0] st;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pip_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pip_hazard_ctrl #(.DM_WAIT_MAX(4), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t  exp_q[$];
   string name_q[$];
   int    errors = 0;
   int    checks = 0;

   function automatic logic [1:0] fw(input logic [1:0] v);
      return FWD ? v : 2'b00;
   endfunction

   task automatic clear_inputs();
      bus.id_rs1_ad = 0; bus.id_rs2_ad = 0; bus.id_rs1_used = 0; bus.id_rs2_used = 0;
      bus.ex_rs1_ad = 0; bus.ex_rs2_ad = 0; bus.ex_rd_ad = 0; bus.ex_rdEn = 0; bus.ex_DMread = 0;
      bus.mem_rd_ad = 0; bus.mem_rdEn = 0; bus.mem_DMread = 0; bus.mem_DMwriteEn = 0;
      bus.wb_rd_ad = 0; bus.wb_rdEn = 0; bus.br_taken = 0; bus.dm_ready = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic expect_out(input string nm, input logic [6:0] en, input logic [1:0] fa,
                             input logic [1:0] fb, input logic to, input int st);
      exp_t e;
      e.en = en; e.fa = fa; e.fb = fb; e.to = to; e.st = 32'(st);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic chk(input string nm, input string field, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s.%s got=%0h expected=%0h", nm, field, got, want);
      end
   endtask

   // Monitor: every cycle's controls are an output event.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "en", 32'({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                               bus.mem_wb_en, bus.if_id_flush, bus.id_ex_bubble}), 32'(e.en));
            chk(nm, "fwd_a", 32'(bus.fwd_a_sel), 32'(e.fa));
            chk(nm, "fwd_b", 32'(bus.fwd_b_sel), 32'(e.fb));
            chk(nm, "timeout", 32'(bus.dm_timeout), 32'(e.to));
            chk(nm, "stall_cycles", bus.stall_cycles, e.st);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      clear_inputs();

      // Reset with hazards present: everything inactive.
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         bus.br_taken = 1; bus.ex_rs1_ad = 5; bus.mem_rd_ad = 5; bus.mem_rdEn = 1;
         expect_out("reset", EN_OFF, 2'b00, 2'b00, 1'b0, 0);
      end

      next_cycle(); rst_n = 1'b1;
      expect_out("release", EN_RUN, 2'b00, 2'b00, 1'b0, 0);

      next_cycle();
      bus.ex_rd_ad = 5; bus.ex_rdEn = 1; bus.ex_DMread = 1; bus.id_rs1_ad = 5; bus.id_rs1_used = 1;
      expect_out("load_use", EN_LU, 2'b00, 2'b00, 1'b0, 0);

      next_cycle();
      bus.wb_rd_ad = 5; bus.wb_rdEn = 1; bus.ex_rs1_ad = 5;
      expect_out("fwd_a_wb", EN_RUN, fw(2'b10), 2'b00, 1'b0, 1);

      next_cycle();
      bus.mem_rd_ad = 7; bus.mem_rdEn = 1; bus.ex_rs2_ad = 7; bus.wb_rd_ad = 7; bus.wb_rdEn = 1;
      expect_out("fwd_b_mem_wins", EN_RUN, 2'b00, fw(2'b01), 1'b0, 1);

      next_cycle();
      bus.mem_rdEn = 1; bus.wb_rdEn = 1; bus.ex_rdEn = 1; bus.ex_DMread = 1;
      bus.id_rs1_used = 1; bus.id_rs2_used = 1;
      expect_out("x0_no_match", EN_RUN, 2'b00, 2'b00, 1'b0, 1);

      next_cycle();
      bus.mem_rd_ad = 9; bus.mem_rdEn = 1; bus.mem_DMread = 1; bus.dm_ready = 1;
      bus.ex_rs1_ad = 9; bus.wb_rd_ad = 9; bus.wb_rdEn = 1;
      expect_out("load_in_mem_uses_wb", EN_RUN, fw(2'b10), 2'b00, 1'b0, 1);

      next_cycle();
      bus.id_rs2_ad = 7; bus.id_rs2_used = 1; bus.ex_rd_ad = 7; bus.ex_rdEn = 1;
      expect_out("raw_ex", FWD ? EN_RUN : EN_LU, 2'b00, 2'b00, 1'b0, 1);

      next_cycle();
      bus.id_rs2_ad = 7; bus.id_rs2_used = 1; bus.mem_rd_ad = 7; bus.mem_rdEn = 1;
      expect_out("raw_mem", FWD ? EN_RUN : EN_LU, 2'b00, 2'b00, 1'b0, FWD ? 1 : 2);

      next_cycle();
      bus.id_rs2_ad = 7; bus.id_rs2_used = 1; bus.wb_rd_ad = 7; bus.wb_rdEn = 1;
      expect_out("raw_wb_no_stall", EN_RUN, 2'b00, 2'b00, 1'b0, S);

      next_cycle();
      bus.ex_rd_ad = 5; bus.ex_rdEn = 1; bus.ex_DMread = 1; bus.id_rs1_ad = 5;
      bus.id_rs1_used = 1; bus.br_taken = 1;
      expect_out("branch_over_load_use", EN_BR, 2'b00, 2'b00, 1'b0, S);

      // Store waits three cycles, dm_ready arrives with a taken branch.
      next_cycle(); bus.mem_DMwriteEn = 1;
      expect_out("store_wait1", EN_OFF, 2'b00, 2'b00, 1'b0, S);
      next_cycle(); bus.mem_DMwriteEn = 1;
      expect_out("store_wait2", EN_OFF, 2'b00, 2'b00, 1'b0, S + 1);
      next_cycle(); bus.mem_DMwriteEn = 1; bus.br_taken = 1;
      expect_out("store_wait3_br_held", EN_OFF, 2'b00, 2'b00, 1'b0, S + 2);
      next_cycle(); bus.mem_DMwriteEn = 1; bus.dm_ready = 1; bus.br_taken = 1;
      expect_out("store_resume", EN_BR, 2'b00, 2'b00, 1'b0, S + 3);
      next_cycle();
      expect_out("after_store", EN_RUN, 2'b00, 2'b00, 1'b0, S + 3);

      // Load never completes: timeout after four MEM_WAIT cycles.
      for (int i = 0; i < 5; i++) begin
         next_cycle(); bus.mem_DMread = 1; bus.mem_rdEn = 1;
         expect_out("load_wait", EN_OFF, 2'b00, 2'b00, 1'b0, S + 3 + i);
      end
      next_cycle(); bus.mem_DMread = 1; bus.dm_ready = 1;
      expect_out("halt_ignores_ready", EN_OFF, 2'b00, 2'b00, 1'b1, S + 8);
      next_cycle();
      expect_out("halt_persists", EN_OFF, 2'b00, 2'b00, 1'b1, S + 9);

      next_cycle(); rst_n = 1'b0;
      expect_out("async_reset", EN_OFF, 2'b00, 2'b00, 1'b0, 0);
      next_cycle(); rst_n = 1'b1;
      expect_out("rerelease", EN_RUN, 2'b00, 2'b00, 1'b0, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain got=%0d expected=0 pending", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pip_hazard_ctrl.md
Name: pip_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It drives the per-stage pip_en inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus PC enable, bubble and flush controls. It generates EX-stage operand forwarding selects. It also handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits with a timeout trap.

Parameters:
DM_WAIT_MAX, 15, max consecutive cycles waiting on dm_ready before timeout (1..255)
CNT_W, 32, width of stall performance counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_rs1_ad  input  5  rs1 address of instruction in ID
id_rs2_ad  input  5  rs2 address of instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
ex_rs1_ad  input  5  rs1 address held in ID/EX
ex_rs2_ad  input  5  rs2 address held in ID/EX
ex_rd_ad  input  5  rd address held in ID/EX
ex_rdEn  input  1  ID/EX instruction writes rd
ex_DMread  input  1  ID/EX instruction is a load
mem_rd_ad  input  5  rd address held in EX/MEM
mem_rdEn  input  1  EX/MEM instruction writes rd
mem_DMread  input  1  EX/MEM instruction is a load
mem_DMwriteEn  input  1  EX/MEM instruction is a store
wb_rd_ad  input  5  rd address held in MEM/WB
wb_rdEn  input  1  MEM/WB instruction writes rd
br_taken  input  1  branch/jump resolved taken in EX
dm_ready  input  1  data memory completes access this cycle
pc_en  output  1  PC update enable
if_id_en  output  1  IF/ID pip_en
id_ex_en  output  1  ID/EX pip_en
ex_mem_en  output  1  EX/MEM pip_en
mem_wb_en  output  1  MEM/WB pip_en
if_id_flush  output  1  load NOP into IF/ID
id_ex_bubble  output  1  load NOP (rdEn=0, DMwriteEn=0, DMread=0) into ID/EX
fwd_a_sel  output  2  EX operand A source: 00 reg, 01 EX/MEM alu_out_p, 10 MEM/WB result
fwd_b_sel  output  2  EX operand B source, same encoding
dm_timeout  output  1  sticky: memory wait exceeded DM_WAIT_MAX
stall_cycles  output  CNT_W  count of cycles with pc_en=0

Behaviour:
- Reset (rst_n low, asynchronous): state=RUN, wait counter=0, dm_timeout=0, stall_cycles=0. While rst_n is low, all enables, flush and bubble are 0 and fwd selects are 00.
- States: RUN, MEM_WAIT, HALT. Control outputs are combinational from state and inputs, so stalls apply in the same cycle.
- Match rule: a source matches a stage when its address is nonzero, the source is used, the stage's rdEn=1, and the addresses are equal. x0 never matches.
- RUN, priority high to low:
  1. (mem_DMread|mem_DMwriteEn)&!dm_ready: all enables 0; next state MEM_WAIT; wait counter=1.
  2. br_taken: all enables 1, if_id_flush=1, id_ex_bubble=1. This gives a 2-cycle penalty. Any load-use stall in the same cycle is ignored.
  3. Load-use: ex_DMread and an ID source matches ex_rd_ad. pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, other enables 1. This lasts exactly one cycle.
  4. Otherwise all enables 1, flush and bubble 0.
- MEM_WAIT: all enables 0. When dm_ready=1, return to RUN and reapply the RUN rules in that cycle. If the counter reaches DM_WAIT_MAX with dm_ready still 0, set dm_timeout and go to HALT. br_taken is held off until exit because EX is frozen.
- HALT: all enables 0 until reset.
- Forwarding (FORWARDING_EN defined), per operand:
  - 01 if ex_rsX_ad matches mem_rd_ad and !mem_DMread.
  - Else 10 if it matches wb_rd_ad.
  - Else 00.
  - The EX/MEM match wins over MEM/WB.
- stall_cycles: increments each cycle pc_en=0 outside reset, including HALT. It saturates at all-ones.

Optional Feature:
FORWARDING_EN: when defined, forwarding selects operate as above and the only RAW stall is load-use. When undefined, fwd_a_sel and fwd_b_sel are tied to 00. Instead, any used ID source that matches ex_rd_ad or mem_rd_ad stalls as in rule 3, held until no match remains. WB-stage hazards rely on the register file's write-through. Rule priorities are unchanged.

Test Plan:
- Reset release, no hazards -> all five enables 1, fwd 00, stall_cycles 0.
- ID/EX: ex_rd_ad=5, ex_rdEn=1, ex_DMread=1; ID id_rs1_ad=5 used -> one cycle pc_en=0, if_id_en=0, id_ex_bubble=1. Next cycle with wb_rd_ad=5 at ex_rs1_ad=5 -> fwd_a_sel=10. stall_cycles=1.
- mem_rd_ad=7 (ALU op) with ex_rs2_ad=7, and wb_rd_ad=7 also -> fwd_b_sel=01. Rerun without FORWARDING_EN with ID rs2=7 against ex_rd_ad=7 -> 2 stall cycles.
- br_taken=1 together with a load-use match -> if_id_flush=1, id_ex_bubble=1, pc_en=1.
- Store in MEM, dm_ready low 3 cycles then high -> enables 0 for 3 cycles, resume on the 4th cycle, dm_timeout=0.
- dm_ready held low with DM_WAIT_MAX=4 -> dm_timeout=1 after 4 cycles, HALT persists. Asserting rst_n=0 mid-HALT clears everything asynchronously.
